// File: rtl/fsm_dwell_sequencer.sv
// Four-state control sequencer (IDLE -> A -> B -> C -> IDLE) with a dwell watchdog
// that forces a return to IDLE when a non-IDLE state is held too long.
module fsm_dwell_sequencer #(
  parameter int MAX_DWELL = 3,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_done,
  input  logic             b_done,
  input  logic             c_done,
  input  logic             abort,
  output logic [2:0]       current_state,
  output logic             busy,
  output logic             seq_done,
  output logic             timeout,
  output logic [2:0]       timeout_state,
  output logic [ERR_W-1:0] timeout_count
);

  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam logic [DW-1:0] DWELL_LIMIT = DW'(MAX_DWELL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STATE_A = 3'd1,
    STATE_B = 3'd2,
    STATE_C = 3'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_next;
  logic          seq_done_next;
  logic          timeout_next;
  logic          own_done;
  logic          dwell_expired;

  // State register; every output is registered here so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dwell         <= '0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      timeout       <= 1'b0;
      timeout_state <= IDLE;
      timeout_count <= '0;
    end else begin
      state    <= next_state;
      dwell    <= dwell_next;
      busy     <= (next_state != IDLE);
      seq_done <= seq_done_next;
      timeout  <= timeout_next;
      if (timeout_next) begin
        timeout_state <= state;
        if (timeout_count != '1) begin
          timeout_count <= timeout_count + 1'b1;
        end
      end
    end
  end

  assign dwell_expired = (dwell == DWELL_LIMIT);

  // Priority in busy states: abort, then own done, then watchdog expiry, else hold.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        next_state = start ? STATE_A : IDLE;
      end
      STATE_A: begin
        if (abort)              next_state = IDLE;
        else if (a_done)        next_state = STATE_B;
        else if (dwell_expired) next_state = IDLE;
        else                    next_state = STATE_A;
      end
      STATE_B: begin
        if (abort)              next_state = IDLE;
        else if (b_done)        next_state = STATE_C;
        else if (dwell_expired) next_state = IDLE;
        else                    next_state = STATE_B;
      end
      STATE_C: begin
        if (abort)              next_state = IDLE;
        else if (c_done)        next_state = IDLE;
        else if (dwell_expired) next_state = IDLE;
        else                    next_state = STATE_C;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Pulse and dwell-counter updates; illegal encodings fall through with no pulses.
  always_comb begin
    own_done      = 1'b0;
    seq_done_next = 1'b0;
    timeout_next  = 1'b0;
    dwell_next    = '0;
    case (state)
      STATE_A: own_done = a_done;
      STATE_B: own_done = b_done;
      STATE_C: own_done = c_done;
      default: own_done = 1'b0;
    endcase
    if (state == STATE_A || state == STATE_B || state == STATE_C) begin
      seq_done_next = (state == STATE_C) && !abort && c_done;
      timeout_next  = !abort && !own_done && dwell_expired;
      if (next_state == state) begin
        dwell_next = dwell_expired ? dwell : dwell + 1'b1;
      end
    end
  end

  assign current_state = state;

endmodule

// File: tb/tb_fsm_dwell_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run against a cycle-level
// reference model built from the sequencer's transition and dwell rules.
module tb_fsm_dwell_sequencer;

  localparam int MAX_DWELL = 3;

  logic       clk = 1'b0;
  logic       rst, start, a_done, b_done, c_done, abort;
  logic [2:0] current_state, timeout_state, cs2, ts2;
  logic       busy, seq_done, timeout, busy2, sd2, to2;
  logic [7:0] timeout_count;
  logic [1:0] tc2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state number, cycles visible in it, pulses and an unbounded timeout tally.
  int m_state = 0, m_vis = 0, m_to_state = 0, m_to_cnt = 0;
  bit m_seq = 0, m_to = 0;

  always #5 clk = ~clk;

  fsm_dwell_sequencer #(.MAX_DWELL(MAX_DWELL), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_done(a_done), .b_done(b_done),
    .c_done(c_done), .abort(abort), .current_state(current_state), .busy(busy),
    .seq_done(seq_done), .timeout(timeout), .timeout_state(timeout_state),
    .timeout_count(timeout_count)
  );

  fsm_dwell_sequencer #(.MAX_DWELL(MAX_DWELL), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .a_done(a_done), .b_done(b_done),
    .c_done(c_done), .abort(abort), .current_state(cs2), .busy(busy2),
    .seq_done(sd2), .timeout(to2), .timeout_state(ts2), .timeout_count(tc2)
  );

  task automatic model_step();
    int nxt;
    bit own;
    m_seq = 0;
    m_to  = 0;
    if (rst) begin
      m_state = 0; m_vis = 0; m_to_state = 0; m_to_cnt = 0;
      return;
    end
    nxt = m_state;
    own = (m_state == 1 && a_done) || (m_state == 2 && b_done) || (m_state == 3 && c_done);
    if (m_state == 0) begin
      if (start) nxt = 1;
    end else if (abort) begin
      nxt = 0;
    end else if (own) begin
      nxt   = (m_state + 1) % 4;
      m_seq = (m_state == 3);
    end else if (m_vis == MAX_DWELL + 1) begin
      nxt        = 0;
      m_to       = 1;
      m_to_state = m_state;
      m_to_cnt++;
    end
    m_vis   = (nxt == m_state) ? m_vis + 1 : 1;
    m_state = nxt;
  endtask

  function automatic logic [16:0] exp_main();
    int c = (m_to_cnt > 255) ? 255 : m_to_cnt;
    return {m_state[2:0], (m_state != 0), m_seq, m_to, m_to_state[2:0], c[7:0]};
  endfunction

  function automatic logic [10:0] exp_sec();
    int c = (m_to_cnt > 3) ? 3 : m_to_cnt;
    return {m_state[2:0], (m_state != 0), m_seq, m_to, m_to_state[2:0], c[1:0]};
  endfunction

  task automatic drive(input logic s, input logic a, input logic b, input logic c,
                       input logic ab, input logic r);
    start = s; a_done = a; b_done = b; c_done = c; abort = ab; rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 1);
    n_tests++;
    if ({current_state, busy, seq_done, timeout, timeout_state, timeout_count, tc2} !== 19'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %h expected %h",
               {current_state, busy, seq_done, timeout, timeout_state, timeout_count, tc2}, 19'd0);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({current_state, busy} !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_release_idle: got %h expected %h", {current_state, busy}, 4'd0);
    end
  endtask

  task automatic test_normal_run();
    logic [4:0] stim [4] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010};
    int exp_s [4] = '{1, 2, 3, 0};
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0], 0);
      n_tests++;
      if ({current_state, busy, seq_done, timeout} !== {exp_s[i][2:0], (exp_s[i] != 0), (i == 3), 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL normal_step%0d: got %h expected %h", i,
                 {current_state, busy, seq_done, timeout}, {exp_s[i][2:0], (exp_s[i] != 0), (i == 3), 1'b0});
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({seq_done, timeout, timeout_count} !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL normal_after: got %h expected %h", {seq_done, timeout, timeout_count}, 10'd0);
    end
  endtask

  task automatic test_stuck_a();
    int vis = 1;
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && current_state == 3'd1; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (current_state == 3'd1) vis++;
    end
    n_tests++;
    if (vis != MAX_DWELL + 1) begin
      n_fail++;
      $display("[TB] FAIL stuck_a_visible: got %0d cycles expected %0d", vis, MAX_DWELL + 1);
    end
    n_tests++;
    if ({current_state, busy, timeout, timeout_state, timeout_count, tc2} !== {3'd0, 1'b0, 1'b1, 3'd1, 8'd1, 2'd1}) begin
      n_fail++;
      $display("[TB] FAIL stuck_a_timeout: got %h expected %h",
               {current_state, busy, timeout, timeout_state, timeout_count, tc2}, {3'd0, 1'b0, 1'b1, 3'd1, 8'd1, 2'd1});
    end
    drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({timeout, timeout_state, timeout_count} !== {1'b0, 3'd1, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL stuck_a_pulse_end: got %h expected %h", {timeout, timeout_state, timeout_count}, {1'b0, 3'd1, 8'd1});
    end
  endtask

  task automatic test_boundary_done();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < MAX_DWELL; k++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    n_tests++;
    if ({current_state, timeout, timeout_count} !== {3'd3, 1'b0, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL boundary_b_done: got %h expected %h", {current_state, timeout, timeout_count}, {3'd3, 1'b0, 8'd0});
    end
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < MAX_DWELL; k++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({current_state, timeout, timeout_state, timeout_count} !== {3'd0, 1'b1, 3'd2, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL boundary_b_expired: got %h expected %h",
               {current_state, timeout, timeout_state, timeout_count}, {3'd0, 1'b1, 3'd2, 8'd1});
    end
    drive(0, 0, 1, 0, 0, 0);
    n_tests++;
    if ({current_state, busy, timeout} !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL boundary_late_b_done: got %h expected %h", {current_state, busy, timeout}, 5'd0);
    end
  endtask

  task automatic test_idle_hold();
    int bad = 0;
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      if ({current_state, busy, seq_done, timeout, timeout_count} !== 14'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL idle_hold: got %0d disturbed cycles expected 0", bad);
    end
    // A long IDLE stay must leave the dwell counter clear: a fresh A still gets its full budget.
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < MAX_DWELL; k++) drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({current_state, timeout} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL idle_then_full_dwell: got %h expected %h", {current_state, timeout}, {3'd1, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({current_state, timeout} !== {3'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL idle_then_expiry: got %h expected %h", {current_state, timeout}, {3'd0, 1'b1});
    end
  endtask

  task automatic test_priority();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    n_tests++;
    if ({current_state, busy, seq_done, timeout} !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_vs_c_done: got %h expected %h", {current_state, busy, seq_done, timeout}, 6'd0);
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < MAX_DWELL; k++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    n_tests++;
    if ({current_state, timeout, timeout_state, timeout_count} !== {3'd0, 1'b0, 3'd0, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL abort_vs_expiry: got %h expected %h",
               {current_state, timeout, timeout_state, timeout_count}, {3'd0, 1'b0, 3'd0, 8'd0});
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    n_tests++;
    if ({current_state, busy, seq_done, timeout, timeout_state, timeout_count} !== 17'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_b: got %h expected %h",
               {current_state, busy, seq_done, timeout, timeout_state, timeout_count}, 17'd0);
    end
    drive(1, 0, 0, 0, 0, 1);
    n_tests++;
    if ({current_state, busy} !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_over_start: got %h expected %h", {current_state, busy}, 4'd0);
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < MAX_DWELL; k++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    n_tests++;
    if ({current_state, timeout, timeout_state, timeout_count} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_drops_timeout: got %h expected %h",
               {current_state, timeout, timeout_state, timeout_count}, 15'd0);
    end
  endtask

  task automatic test_saturation();
    drive(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 5; n++) begin
      drive(1, 0, 0, 0, 0, 0);
      for (int k = 0; k <= MAX_DWELL; k++) drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
    end
    n_tests++;
    if ({tc2, timeout_count} !== {2'd3, 8'd5}) begin
      n_fail++;
      $display("[TB] FAIL saturation: got %h expected %h", {tc2, timeout_count}, {2'd3, 8'd5});
    end
  endtask

  task automatic test_random();
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
      n_tests++;
      if ({current_state, busy, seq_done, timeout, timeout_state, timeout_count} !== exp_main() ||
          {cs2, busy2, sd2, to2, ts2, tc2} !== exp_sec()) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: got %h/%h expected %h/%h", k,
                 {current_state, busy, seq_done, timeout, timeout_state, timeout_count},
                 {cs2, busy2, sd2, to2, ts2, tc2}, exp_main(), exp_sec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_done = 1'b0; b_done = 1'b0; c_done = 1'b0; abort = 1'b0;
    test_reset();
    test_normal_run();
    test_stuck_a();
    test_boundary_done();
    test_idle_hold();
    test_priority();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
